// File: rtl/addsub_arb_2_pkg.sv
// Shared encodings for the two-requester add/sub arbiter.
package addsub_arb_2_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_arb_2_addsub_unit.sv
// Combinational (W+1)-bit add/subtract; bit W is carry on add, borrow on subtract.
module addsub_unit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         c_out
);

  always_comb begin
    if (sub) {c_out, sum} = {1'b0, a} - {1'b0, b};
    else     {c_out, sum} = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/addsub_arb_2.sv
// Round-robin arbiter sharing one add/sub unit between two requesters.
// state | meaning
// IDLE  | waiting for a request; grants and latches operands on request
// EXEC  | shared unit works on latched operands; result registered at exit
import addsub_arb_2_pkg::*;

module addsub_arb_2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         op0,
  input  logic         op1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done,
  output logic [W-1:0] res,
  output logic         c_out,
  output logic         res_id,
  output logic         busy
);

  state_e       state_q, state_d;
  logic         last_q, last_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         op_q, op_d, id_q, id_d;
  logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d, done_q, done_d;
  logic [W-1:0] res_q, res_d;
  logic         cout_q, cout_d, res_id_q, res_id_d;
  logic [W-1:0] unit_sum;
  logic         unit_cout;
  logic         pick;

  addsub_unit #(.W(W)) u_addsub (
    .a     (a_q),
    .b     (b_q),
    .sub   (op_q == OP_SUB),
    .sum   (unit_sum),
    .c_out (unit_cout)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done_d   = 1'b0;
    res_d    = res_q;
    cout_d   = cout_q;
    res_id_d = res_id_q;
    pick     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On contention the requester not granted last wins.
          pick    = (req0 && req1) ? ~last_q : req1;
          a_d     = pick ? a1 : a0;
          b_d     = pick ? b1 : b0;
          op_d    = pick ? op1 : op0;
          id_d    = pick;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          last_d  = pick;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d    = unit_sum;
        cout_d   = unit_cout;
        res_id_d = id_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      id_q     <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done_q   <= 1'b0;
      res_q    <= '0;
      cout_q   <= 1'b0;
      res_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done_q   <= done_d;
      res_q    <= res_d;
      cout_q   <= cout_d;
      res_id_q <= res_id_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign done   = done_q;
  assign res    = res_q;
  assign c_out  = cout_q;
  assign res_id = res_id_q;
  assign busy   = (state_q == EXEC);

endmodule

// File: tb/tb_addsub_arb_2.sv
// Self-checking bench for addsub_arb_2: directed scenarios plus random traffic vs. a behavioural model.
module tb_addsub_arb_2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done, c_out, res_id, busy;
  logic [3:0] res;

  int n_chk = 0;
  int n_fail = 0;

  // behavioural model state
  bit m_pending;
  int m_a, m_b, m_op, m_id, m_last;
  int e_gnt0, e_gnt1, e_done, e_res, e_cout, e_id;

  addsub_arb_2 #(.W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done(done),
    .res(res), .c_out(c_out), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_step();
    int r;
    int w;
    e_gnt0 = 0;
    e_gnt1 = 0;
    e_done = 0;
    if (rst) begin
      m_pending = 0;
      e_res = 0; e_cout = 0; e_id = 0;
      m_last = 1;
    end else if (m_pending) begin
      r = (m_op == 1) ? (m_a - m_b) : (m_a + m_b);
      r = ((r % 32) + 32) % 32;
      e_res  = r % 16;
      e_cout = r / 16;
      e_id   = m_id;
      e_done = 1;
      m_pending = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) w = (m_last == 0) ? 1 : 0;
      else              w = req1 ? 1 : 0;
      m_a  = (w == 1) ? int'(a1) : int'(a0);
      m_b  = (w == 1) ? int'(b1) : int'(b0);
      m_op = (w == 1) ? int'(op1) : int'(op0);
      m_id = w;
      m_last = w;
      if (w == 1) e_gnt1 = 1; else e_gnt0 = 1;
      m_pending = 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("gnt0", int'(gnt0), e_gnt0);
    chk("gnt1", int'(gnt1), e_gnt1);
    chk("gnt_onehot", int'(gnt0 & gnt1), 0);
    chk("done", int'(done), e_done);
    chk("busy", int'(busy), int'(m_pending));
    chk("res", int'(res), e_res);
    chk("c_out", int'(c_out), e_cout);
    chk("res_id", int'(res_id), e_id);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int order[$];
    int n_g0, n_g1;
    rst = 1'b1; req0 = 0; req1 = 0; op0 = 0; op1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    m_pending = 0; m_last = 1; m_a = 0; m_b = 0; m_op = 0; m_id = 0;
    e_gnt0 = 0; e_gnt1 = 0; e_done = 0; e_res = 0; e_cout = 0; e_id = 0;
    #1;
    do_reset();
    chk("rst_res", int'(res), 0);
    chk("rst_busy", int'(busy), 0);
    tick();

    // requester 0 add: 2+3
    req0 = 1; a0 = 2; b0 = 3; op0 = 0;
    tick();
    chk("d0_gnt0", int'(gnt0), 1);
    req0 = 0;
    tick();
    chk("d0_done", int'(done), 1);
    chk("d0_res", int'(res), 5);
    chk("d0_cout", int'(c_out), 0);
    chk("d0_id", int'(res_id), 0);
    tick();
    chk("d0_hold", int'(res), 5);

    // requester 1 subtract with borrow, then add with carry
    req1 = 1; a1 = 2; b1 = 3; op1 = 1;
    tick(); req1 = 0; tick();
    chk("d1_res", int'(res), 15);
    chk("d1_cout", int'(c_out), 1);
    chk("d1_id", int'(res_id), 1);
    req1 = 1; a1 = 15; b1 = 1; op1 = 0;
    tick(); req1 = 0; tick();
    chk("d2_res", int'(res), 0);
    chk("d2_cout", int'(c_out), 1);

    // both held right after reset: round-robin 0,1,0,1
    do_reset();
    req0 = 1; req1 = 1; a0 = 1; b0 = 1; a1 = 7; b1 = 2; op0 = 0; op1 = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    req0 = 0; req1 = 0;
    tick();
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("rr_order", order[i], i % 2);

    // only req0 held: three grants two cycles apart
    tick();
    n_g0 = 0; n_g1 = 0;
    req0 = 1; a0 = 4; b0 = 6; op0 = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt0) n_g0++;
      if (gnt1) n_g1++;
    end
    req0 = 0;
    tick();
    chk("r0_gnt0_cnt", n_g0, 3);
    chk("r0_gnt1_cnt", n_g1, 0);

    // reset during EXEC aborts the operation
    do_reset();
    req0 = 1; a0 = 9; b0 = 4; op0 = 0;
    tick();
    chk("ab_gnt", int'(gnt0), 1);
    req0 = 0; rst = 1;
    tick();
    rst = 0;
    chk("ab_done", int'(done), 0);
    chk("ab_res", int'(res), 0);
    tick();
    chk("ab_nodone", int'(done), 0);
    req0 = 1; a0 = 9; b0 = 4; op0 = 1;
    tick(); req0 = 0; tick();
    chk("ab_after_done", int'(done), 1);
    chk("ab_after_res", int'(res), 5);

    // random traffic honouring the hold-until-grant protocol
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      tick();
      if (gnt0 || !req0) begin
        req0 = $urandom_range(0, 2) != 0;
        a0 = 4'($urandom); b0 = 4'($urandom); op0 = 1'($urandom);
      end
      if (gnt1 || !req1) begin
        req1 = $urandom_range(0, 2) != 0;
        a1 = 4'($urandom); b1 = 4'($urandom); op1 = 1'($urandom);
      end
    end
    rst = 0; req0 = 0; req1 = 0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addsub_arb_2.md
ADDSUB_ARB_2 -- requirements
Module: addsub_arb_2

Interface
REQ-001 Parameter: W, 4, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0, req1  input  1 each  operation request from requester 0 / 1.
REQ-005 a0, b0, a1, b1  input  W each  operands of requester 0 / 1.
REQ-006 op0, op1  input  1 each  0 = add (a+b), 1 = subtract (a-b).
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: operands of that requester were captured.
REQ-008 done  output  1  one-cycle pulse: res, c_out and res_id are valid.
REQ-009 res  output  W  result of the completed operation.
REQ-010 c_out  output  1  bit W of the (W+1)-bit result: carry on add, borrow (a<b) on subtract.
REQ-011 res_id  output  1  requester (0/1) that owns the result.
REQ-012 busy  output  1  high while the state is EXEC.

Function
REQ-013 Two-state FSM, IDLE and EXEC; one shared add/sub unit serves both requesters.
REQ-014 IDLE, no req high: remain IDLE; gnt0, gnt1 and done are low in the next cycle.
REQ-015 IDLE, exactly one req high at an edge: latch that requester's a, b, op and id; enter EXEC; that gnt is high for the following cycle only.
REQ-016 IDLE, both req high: grant the requester not granted last (round-robin); after reset, requester 0 wins first.
REQ-017 The last-granted register updates only on a grant.
REQ-018 EXEC: the shared unit computes {c_out,sum} = a+b (op=0) or a-b (op=1) on the latched operands, with (W+1)-bit modulo-2^(W+1) arithmetic.
REQ-019 At the edge ending EXEC: register sum into res, carry/borrow into c_out and the latched id into res_id; pulse done for one cycle; return to IDLE.
REQ-020 Latency: request sampled at edge T -> gnt high during T..T+1 -> done high during T+1..T+2.
REQ-021 Peak throughput is one operation per 2 cycles.
REQ-022 req is ignored while in EXEC.
REQ-023 Requester protocol: hold req and operands stable until gnt is seen.
REQ-024 A req still high in the IDLE cycle that follows its done is a new request.
REQ-025 res, c_out and res_id hold their values between done pulses.
REQ-026 gnt0 and gnt1 are never high together.
REQ-027 done occurs exactly once per grant, except when the operation is aborted by reset.

Reset
REQ-028 rst high at an edge: state goes to IDLE; gnt0, gnt1, done, busy, res, c_out and res_id go to 0; last-granted goes to 1.
REQ-029 rst during EXEC aborts the in-flight operation: no done and no result update for it.
REQ-030 rst takes priority over every request.
REQ-031 The first grant can occur at the first edge after rst is sampled low.

Structure
REQ-032 A shared package holds the FSM state encoding (IDLE, EXEC) and the op encoding constants (OP_ADD=0, OP_SUB=1).
REQ-033 The combinational add/sub unit is one sub-module, addsub_unit, with ports a, b, sub, sum, c_out and width W; the arbiter instantiates it once.

Verification
REQ-034 req0, a0=2, b0=3, op0=0 -> gnt0 in the next cycle, then done with res=5, c_out=0, res_id=0.
REQ-035 req1, a1=2, b1=3, op1=1 -> done with res=15, c_out=1 (borrow), res_id=1; then a1=15, b1=1, op1=0 -> res=0, c_out=1.
REQ-036 req0 and req1 high together right after reset, both held -> grants in order 0,1,0,1 with done every 2 cycles and res_id matching each grant.
REQ-037 Only req0 held high for 3 operations -> three gnt0 pulses, each 2 cycles apart; gnt1 never asserted.
REQ-038 rst high in the EXEC cycle of an operation with a=9, b=4 -> no done; res stays 0; next request completes normally.
REQ-039 Bench checks on every cycle: gnt one-hot-or-zero, busy equals EXEC, and res/c_out checked against a reference model using 5-bit arithmetic.
